dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
- Resolves the four DMA channel requests into one serviced channel. Requests come from hardware DREQ lines and from software request-register bits.
- Runs the HRQ/HLDA bus-hold handshake with the CPU and drives per-channel DACK while the channel is serviced.
- Sits between the register file (mask, request and command bits) and the transfer-timing FSM, which reports the end of service via xferDone.

Parameters:
- NUM_CH, 4, number of channels; arbitration logic must be generic, but the test plan covers 4 only.
- CH_W, $clog2(NUM_CH), width of the channel index.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- DREQ  input  NUM_CH  hardware request lines; raw polarity.
- maskReg  input  NUM_CH  1 = channel masked; from register file.
- requestReg  input  NUM_CH  software requests; not affected by mask.
- dreqSenseLow  input  1  command bit 6; 1 = DREQ active low.
- dackSenseHigh  input  1  command bit 7; 1 = DACK active high.
- rotatePri  input  1  command bit 4; 1 = rotating priority, 0 = fixed priority.
- ctrlDisable  input  1  command bit 2; 1 = controller disabled, no new arbitration.
- HLDA  input  1  hold acknowledge from the CPU.
- xferDone  input  1  one-cycle pulse from the timing FSM: service of the granted channel has ended.
- HRQ  output  1  hold request to the CPU.
- DACK  output  NUM_CH  acknowledge; polarity set by dackSenseHigh.
- grantValid  output  1  a channel is currently granted.
- grantCh  output  CH_W  index of the granted channel.
- reqClr  output  NUM_CH  one-cycle pulse; clears the granted channel's requestReg bit.

Behaviour:
- Effective request: effReq = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | requestReg.
- Priority:
  - Fixed: channel 0 highest, channel NUM_CH-1 lowest.
  - Rotating: the last-serviced channel becomes lowest; the channel after it (modulo NUM_CH) becomes highest.
  - Rotation pointer lastCh resets to NUM_CH-1, so after reset both modes start from the fixed order.
  - lastCh updates only on leaving GRANT.
- State machine; all state and outputs are registered.
  - IDLE: if |effReq and !ctrlDisable, go to REQ next cycle and assert HRQ.
  - REQ: HRQ=1. If effReq becomes 0, or ctrlDisable rises, go to IDLE and drop HRQ. If HLDA=1, latch the current winner into grantCh and go to GRANT; DACK/grantValid become active the following cycle. The winner is re-resolved every REQ cycle; the latch happens at HLDA.
  - GRANT: HRQ=1, grantValid=1, DACK one-hot on grantCh. The winner is frozen: higher-priority requests arriving now do not preempt. On xferDone, or on HLDA dropping, go to RELEASE.
  - RELEASE (1 cycle): HRQ=0, grantValid=0, DACK inactive. reqClr[grantCh] pulses if requestReg[grantCh]=1. lastCh <= grantCh. Go to IDLE.
- DACK output: dackSenseHigh ? onehot : ~onehot. Inactive value is 0 when sense is high and all-ones when sense is low.
- Minimum gap between services: RELEASE plus IDLE means HRQ stays low for at least 2 cycles before a new HRQ.
- Latency: request to HRQ is 1 cycle. HLDA to DACK is 1 cycle.
- Simultaneous events:
  - xferDone and HLDA drop in the same cycle: single RELEASE.
  - xferDone outside GRANT: ignored.
  - ctrlDisable in GRANT: service completes normally.
- Reset, including mid-operation: state=IDLE, HRQ=0, grantValid=0, grantCh=0, reqClr=0, DACK=inactive per the current dackSenseHigh, lastCh=NUM_CH-1.

Optional Feature:
- Macro: DMA_DREQ_SYNC_EN.
- Defined: DREQ passes through a 2-flop synchronizer (flops reset to the inactive level per dreqSenseLow, sampled at reset) before effReq. Adds 2 cycles of DREQ-to-HRQ latency. requestReg path is unchanged.
- Undefined: DREQ is used directly; the source is assumed synchronous to CLK.

Decomposition:
- Package dma_pkg:
  - arbiter state enum {IDLE, REQ, GRANT, RELEASE}.
  - NUM_CH default constant.
  - command-register bit-position constants (CMD_CTRL_DIS=2, CMD_ROT_PRI=4, CMD_DREQ_LOW=6, CMD_DACK_HIGH=7).
  - channel index typedef.
- Sub-module dma_pri_encoder: combinational; inputs effReq, lastCh, rotatePri; outputs winner index and anyReq.

Test Plan:
- Fixed priority: DREQ=4'b1010 (sense high, mask 0), HLDA after 3 cycles -> HRQ 1 cycle after the request; grantCh=1; DACK=4'b1101 one cycle after HLDA (sense low); xferDone -> HRQ low next cycle.
- Rotating: rotatePri=1, DREQ=4'b1111 held, xferDone after each grant -> grant order 0,1,2,3,0.
- Mask/software: maskReg=4'b0100, DREQ=4'b0100, requestReg=4'b0001 -> channel 0 granted; reqClr=4'b0001 pulse in RELEASE; DREQ2 never granted.
- Request withdrawal: DREQ0 pulses 2 cycles with no HLDA -> HRQ rises, then returns to 0, state returns to IDLE, no DACK.
- Async reset in GRANT with dackSenseHigh=1 -> DACK=0, HRQ=0, grantValid=0 immediately, without waiting for a clock edge; next arbitration uses fixed order.
- DMA_DREQ_SYNC_EN defined: DREQ3 asserted -> HRQ rises 3 cycles later instead of 1.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the DMA priority arbiter
package dma_pkg;

    localparam int DMA_NUM_CH = 4;

    // Command-register bit positions feeding the arbiter control inputs
    localparam int CMD_CTRL_DIS  = 2;
    localparam int CMD_ROT_PRI   = 4;
    localparam int CMD_DREQ_LOW  = 6;
    localparam int CMD_DACK_HIGH = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    typedef logic [$clog2(DMA_NUM_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// rtl/dma_priority_arbiter_if.sv - DREQ/DACK, HRQ/HLDA and grant handshake bundle
interface dma_priority_arbiter_if
    import dma_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0] DREQ;
    logic              HLDA;
    logic              xferDone;
    logic              HRQ;
    logic [NUM_CH-1:0] DACK;
    logic              grantValid;
    logic [CH_W-1:0]   grantCh;
    logic [NUM_CH-1:0] reqClr;

    // master: the arbiter; slave: channel lines, CPU and timing FSM
    modport master (
        input  DREQ, HLDA, xferDone,
        output HRQ, DACK, grantValid, grantCh, reqClr
    );

    modport slave (
        output DREQ, HLDA, xferDone,
        input  HRQ, DACK, grantValid, grantCh, reqClr
    );
endinterface

// File: rtl/dma_pri_encoder.sv
// rtl/dma_pri_encoder.sv - fixed/rotating priority resolver over the effective requests
module dma_pri_encoder #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] eff_req,
    input  logic [CH_W-1:0]   last_ch,
    input  logic              rotate_pri,
    output logic [CH_W-1:0]   winner,
    output logic              any_req
);

    // Scan upward starting just after the lowest-priority channel; fixed mode
    // behaves as if channel NUM_CH-1 had been serviced last.
    always_comb begin
        int              base;
        int              pos;
        logic [CH_W-1:0] sel;
        logic            found;
        winner = '0;
        found  = 1'b0;
        base   = rotate_pri ? int'(last_ch) : NUM_CH - 1;
        for (int k = 1; k <= NUM_CH; k++) begin
            pos = base + k;
            if (pos >= NUM_CH) begin
                pos = pos - NUM_CH;
            end
            sel = CH_W'(pos);
            if (!found && eff_req[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
        any_req = |eff_req;
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// rtl/dma_priority_arbiter.sv - DMA channel arbiter with HRQ/HLDA handshake; optional DMA_DREQ_SYNC_EN
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    dma_priority_arbiter_if.master bus,
    input  logic [NUM_CH-1:0]      maskReg,
    input  logic [NUM_CH-1:0]      requestReg,
    input  logic                   dreqSenseLow,
    input  logic                   dackSenseHigh,
    input  logic                   rotatePri,
    input  logic                   ctrlDisable
);

    localparam logic [NUM_CH-1:0] ONE_LSB = NUM_CH'(1);

    arb_state_e        state_q, state_d;
    logic              hrq_q, hrq_d;
    logic              grant_valid_q, grant_valid_d;
    logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
    logic [NUM_CH-1:0] dack_oh_q, dack_oh_d;
    logic [NUM_CH-1:0] req_clr_q, req_clr_d;
    logic [CH_W-1:0]   last_ch_q, last_ch_d;

    logic [NUM_CH-1:0] dreq_raw;
    logic [NUM_CH-1:0] eff_req;
    logic [CH_W-1:0]   winner;
    logic              any_req;

`ifdef DMA_DREQ_SYNC_EN
    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;

    // Two-stage DREQ synchronizer input selection
    always_comb begin
        sync1_d = bus.DREQ;
        sync2_d = sync1_q;
    end

    // Synchronizer flops come out of reset at the inactive DREQ level
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= {NUM_CH{dreqSenseLow}};
            sync2_q <= {NUM_CH{dreqSenseLow}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign dreq_raw = sync2_q;
`else
    assign dreq_raw = bus.DREQ;
`endif

    // Software requests bypass the mask; hardware requests are polarity-corrected first
    assign eff_req = ((dreq_raw ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | requestReg;

    dma_pri_encoder #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pri_encoder (
        .eff_req    (eff_req),
        .last_ch    (last_ch_q),
        .rotate_pri (rotatePri),
        .winner     (winner),
        .any_req    (any_req)
    );

    // State and registered-output flops
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            hrq_q         <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_ch_q    <= '0;
            dack_oh_q     <= '0;
            req_clr_q     <= '0;
            last_ch_q     <= CH_W'(NUM_CH - 1);
        end else begin
            state_q       <= state_d;
            hrq_q         <= hrq_d;
            grant_valid_q <= grant_valid_d;
            grant_ch_q    <= grant_ch_d;
            dack_oh_q     <= dack_oh_d;
            req_clr_q     <= req_clr_d;
            last_ch_q     <= last_ch_d;
        end
    end

    // Next-state: request, bus hold, frozen service, one-cycle release
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req && !ctrlDisable) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!any_req || ctrlDisable) begin
                    state_d = IDLE;
                end else if (bus.HLDA) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.xferDone || !bus.HLDA) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the transition being taken
    always_comb begin
        hrq_d         = (state_d == REQ) || (state_d == GRANT);
        grant_valid_d = (state_d == GRANT);
        grant_ch_d    = grant_ch_q;
        if (state_q == REQ && state_d == GRANT) begin
            grant_ch_d = winner;
        end
        dack_oh_d = '0;
        if (state_d == GRANT) begin
            dack_oh_d = ONE_LSB << grant_ch_d;
        end
        req_clr_d = '0;
        last_ch_d = last_ch_q;
        if (state_q == GRANT && state_d == RELEASE) begin
            last_ch_d = grant_ch_q;
            req_clr_d = requestReg & (ONE_LSB << grant_ch_q);
        end
    end

    assign bus.HRQ        = hrq_q;
    assign bus.grantValid = grant_valid_q;
    assign bus.grantCh    = grant_ch_q;
    assign bus.reqClr     = req_clr_q;
    assign bus.DACK       = dackSenseHigh ? dack_oh_q : ~dack_oh_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb/tb_dma_priority_arbiter.sv - self-checking bench for dma_priority_arbiter
module tb_dma_priority_arbiter;
    import dma_pkg::*;

    localparam int N = 4;
`ifdef DMA_DREQ_SYNC_EN
    localparam int REQ_LAT = 3;
`else
    localparam int REQ_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   cmd;
    logic [N-1:0] mask_reg;
    logic [N-1:0] request_reg;
    logic         dreq_low, dack_high, rot_pri, ctrl_dis;

    assign dreq_low  = cmd[CMD_DREQ_LOW];
    assign dack_high = cmd[CMD_DACK_HIGH];
    assign rot_pri   = cmd[CMD_ROT_PRI];
    assign ctrl_dis  = cmd[CMD_CTRL_DIS];

    dma_priority_arbiter_if #(.NUM_CH(N)) bus ();

    dma_priority_arbiter #(.NUM_CH(N)) dut (
        .CLK           (clk),
        .RESET         (rst),
        .bus           (bus),
        .maskReg       (mask_reg),
        .requestReg    (request_reg),
        .dreqSenseLow  (dreq_low),
        .dackSenseHigh (dack_high),
        .rotatePri     (rot_pri),
        .ctrlDisable   (ctrl_dis)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int model_last;

    typedef struct {
        logic [N-1:0] dreq;
        logic [N-1:0] mask;
        logic [N-1:0] rreg;
        logic         dlow;
        logic         dhigh;
        int           ch;
        logic [N-1:0] clr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_eff(input logic [N-1:0] dreq, input logic [N-1:0] mask,
                                             input logic [N-1:0] rreg, input logic low);
        logic [N-1:0] active;
        active = low ? ~dreq : dreq;
        return (active & ~mask) | rreg;
    endfunction

    function automatic int ref_winner(input logic [N-1:0] eff, input int last, input logic rot);
        int first;
        int c;
        first = rot ? (last + 1) % N : 0;
        for (int k = 0; k < N; k++) begin
            c = (first + k) % N;
            if (eff[c[1:0]]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] dack_val(input int ch, input logic high);
        logic [N-1:0] oh;
        oh = '0;
        if (ch >= 0) oh[ch[1:0]] = 1'b1;
        return high ? oh : ~oh;
    endfunction

    task automatic do_reset(input logic low);
        @(negedge clk);
        cmd[CMD_DREQ_LOW] = low;
        bus.DREQ     = {N{low}};
        bus.HLDA     = 1'b0;
        bus.xferDone = 1'b0;
        request_reg  = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = N - 1;
        @(negedge clk);
    endtask

    task automatic wait_hrq(input string tag, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.HRQ && cnt < 12);
        check({tag, " hrq rise"}, int'(bus.HRQ), 1);
    endtask

    task automatic service(input string tag, input logic [N-1:0] dreq, input logic [N-1:0] mask,
                           input logic [N-1:0] rreg, input logic dhigh, input logic rot,
                           input int exp_ch, input logic [N-1:0] exp_clr, input int rel_mode);
        int cnt;
        int exp_lat;
        exp_lat = (rreg != '0) ? 1 : REQ_LAT;
        cmd[CMD_DACK_HIGH] = dhigh;
        cmd[CMD_ROT_PRI]   = rot;
        mask_reg    = mask;
        request_reg = rreg;
        bus.DREQ    = dreq;
        #1;
        check({tag, " idle dack"}, int'(bus.DACK), int'(dack_val(-1, dhigh)));
        wait_hrq(tag, cnt);
        check({tag, " hrq latency"}, cnt, exp_lat);
        repeat (2) @(negedge clk);
        check({tag, " hrq held"}, int'(bus.HRQ), 1);
        bus.HLDA = 1'b1;
        @(negedge clk);
        check({tag, " grant valid"}, int'(bus.grantValid), 1);
        check({tag, " grant ch"}, int'(bus.grantCh), exp_ch);
        check({tag, " dack"}, int'(bus.DACK), int'(dack_val(exp_ch, dhigh)));
        bus.DREQ     = {N{dreq_low}};
        bus.xferDone = (rel_mode != 1);
        bus.HLDA     = (rel_mode == 0);
        @(negedge clk);
        bus.xferDone = 1'b0;
        bus.HLDA     = 1'b0;
        check({tag, " release hrq"}, int'(bus.HRQ), 0);
        check({tag, " release valid"}, int'(bus.grantValid), 0);
        check({tag, " release dack"}, int'(bus.DACK), int'(dack_val(-1, dhigh)));
        check({tag, " reqclr"}, int'(bus.reqClr), int'(exp_clr));
        request_reg = '0;
        @(negedge clk);
        check({tag, " reqclr end"}, int'(bus.reqClr), 0);
        @(negedge clk);
        check({tag, " gap hrq"}, int'(bus.HRQ), 0);
        model_last = exp_ch;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        int  saw_hrq;
        int  saw_dack;

        vecs[0] = '{4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 4'b0000};
        vecs[1] = '{4'b0100, 4'b0100, 4'b0001, 1'b0, 1'b1, 0, 4'b0001};
        vecs[2] = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 3, 4'b0000};
        vecs[3] = '{4'b1011, 4'b0000, 4'b0000, 1'b1, 1'b0, 2, 4'b0000};
        vecs[4] = '{4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b1, 3, 4'b1000};
        vecs[5] = '{4'b1100, 4'b0100, 4'b0000, 1'b0, 1'b0, 3, 4'b0000};
        vecs[6] = '{4'b0110, 4'b0010, 4'b1000, 1'b0, 1'b1, 2, 4'b0000};
        vecs[7] = '{4'b0000, 4'b0000, 4'b0110, 1'b1, 1'b0, 0, 4'b0000};

        rst          = 1'b1;
        cmd          = 8'h00;
        mask_reg     = '0;
        request_reg  = '0;
        bus.DREQ     = '0;
        bus.HLDA     = 1'b0;
        bus.xferDone = 1'b0;
        model_last   = N - 1;

        @(negedge clk);
        check("reset hrq", int'(bus.HRQ), 0);
        check("reset valid", int'(bus.grantValid), 0);
        check("reset grant ch", int'(bus.grantCh), 0);
        check("reset reqclr", int'(bus.reqClr), 0);
        check("reset dack", int'(bus.DACK), 4'b1111);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].dlow != dreq_low) do_reset(vecs[i].dlow);
            service($sformatf("vec%0d", i), vecs[i].dreq, vecs[i].mask, vecs[i].rreg,
                    vecs[i].dhigh, 1'b0, vecs[i].ch, vecs[i].clr, i % 3);
        end

        // Request withdrawn before HLDA: HRQ rises and falls, no DACK
        do_reset(1'b0);
        cmd[CMD_DACK_HIGH] = 1'b1;
        cmd[CMD_ROT_PRI]   = 1'b0;
        mask_reg = '0;
        saw_hrq  = 0;
        saw_dack = 0;
        bus.DREQ = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.DREQ = 4'b0000;
            if (bus.HRQ) saw_hrq = 1;
            if (bus.DACK != 4'b0000 || bus.grantValid) saw_dack = 1;
        end
        check("withdraw saw hrq", saw_hrq, 1);
        check("withdraw no dack", saw_dack, 0);
        check("withdraw hrq end", int'(bus.HRQ), 0);

        // Masked hardware request never raises HRQ
        mask_reg = 4'b0100;
        bus.DREQ = 4'b0100;
        saw_hrq  = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.HRQ) saw_hrq = 1;
        end
        check("masked no hrq", saw_hrq, 0);
        bus.DREQ = 4'b0000;
        mask_reg = '0;

        // Disabled controller ignores requests; disable during GRANT does not abort
        cmd[CMD_CTRL_DIS] = 1'b1;
        bus.DREQ = 4'b0001;
        saw_hrq  = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.HRQ) saw_hrq = 1;
        end
        check("disabled no hrq", saw_hrq, 0);
        cmd[CMD_CTRL_DIS] = 1'b0;
        bus.DREQ = 4'b1000;
        wait_hrq("disable grant", cnt);
        repeat (2) @(negedge clk);
        bus.HLDA = 1'b1;
        @(negedge clk);
        check("disable grant ch", int'(bus.grantCh), 3);
        cmd[CMD_CTRL_DIS] = 1'b1;
        bus.DREQ = 4'b1001;
        @(negedge clk);
        check("no preempt valid", int'(bus.grantValid), 1);
        check("no preempt ch", int'(bus.grantCh), 3);
        check("no preempt dack", int'(bus.DACK), 4'b1000);
        bus.DREQ     = 4'b0000;
        bus.xferDone = 1'b1;
        bus.HLDA     = 1'b0;
        @(negedge clk);
        bus.xferDone = 1'b0;
        cmd[CMD_CTRL_DIS] = 1'b0;
        check("disable release valid", int'(bus.grantValid), 0);
        repeat (3) @(negedge clk);

        // Rotating priority with all requests held: 0,1,2,3,0
        do_reset(1'b0);
        cmd[CMD_ROT_PRI]   = 1'b1;
        cmd[CMD_DACK_HIGH] = 1'b0;
        bus.DREQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_hrq($sformatf("rot%0d", i), cnt);
            check($sformatf("rot%0d hrq delay", i), cnt, (i == 0) ? REQ_LAT : 2);
            bus.HLDA = 1'b1;
            @(negedge clk);
            check($sformatf("rot%0d grant ch", i), int'(bus.grantCh), i % N);
            check($sformatf("rot%0d model ch", i), int'(bus.grantCh),
                  ref_winner(4'b1111, model_last, 1'b1));
            model_last = i % N;
            bus.xferDone = 1'b1;
            bus.HLDA     = 1'b0;
            @(negedge clk);
            bus.xferDone = 1'b0;
            check($sformatf("rot%0d release hrq", i), int'(bus.HRQ), 0);
        end

        // Asynchronous reset while granted, then fixed order restarts
        cmd[CMD_DACK_HIGH] = 1'b1;
        wait_hrq("areset", cnt);
        bus.HLDA = 1'b1;
        @(negedge clk);
        check("areset pre ch", int'(bus.grantCh), 1);
        check("areset pre dack", int'(bus.DACK), 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("areset dack", int'(bus.DACK), 0);
        check("areset hrq", int'(bus.HRQ), 0);
        check("areset valid", int'(bus.grantValid), 0);
        check("areset ch", int'(bus.grantCh), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.HLDA = 1'b0;
        model_last = N - 1;
        wait_hrq("post reset", cnt);
        bus.HLDA = 1'b1;
        @(negedge clk);
        check("post reset ch", int'(bus.grantCh), 0);
        bus.DREQ     = 4'b0000;
        bus.xferDone = 1'b1;
        bus.HLDA     = 1'b0;
        @(negedge clk);
        bus.xferDone = 1'b0;
        model_last = 0;
        repeat (3) @(negedge clk);

        // Randomized services against the reference model
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] r_dreq, r_mask, r_rreg, r_eff, r_clr;
            logic         r_rot, r_dhigh;
            int           w;
            if ($urandom_range(0, 5) == 0) do_reset(~dreq_low);
            do begin
                r_dreq = 4'($urandom);
                r_mask = 4'($urandom);
                r_rreg = '0;
                if ($urandom_range(0, 3) == 0) r_rreg = 4'($urandom);
                r_eff = ref_eff(r_dreq, r_mask, r_rreg, dreq_low);
            end while (r_eff == '0);
            r_rot   = 1'($urandom);
            r_dhigh = 1'($urandom);
            w       = ref_winner(r_eff, model_last, r_rot);
            r_clr   = r_rreg & dack_val(w, 1'b1);
            service($sformatf("rnd%0d", t), r_dreq, r_mask, r_rreg, r_dhigh, r_rot,
                    w, r_clr, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
